// File: rtl/lsu_mem_responder_pkg.sv
// Shared memory-map and timing constants for the LS data port and its memory responder.
// The core and the responder both import these so that their address maps and latencies agree.
package lsu_mem_responder_pkg;

  localparam int unsigned     XLEN           = 64;
  localparam int unsigned     NLANES         = XLEN / 8;
  localparam logic [XLEN-1:0] MEM_BASE_ADDR  = 64'h8000_0000;
  localparam int unsigned     MEM_DEPTH_LOG2 = 12;
  localparam int unsigned     MEM_LAT        = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/lsu_mem_responder_ram.sv
// Single-port storage with byte-lane write enables and a registered read. Contents are not reset.
// Read data appears one edge after en_i; a store returns the old word on rdata_o, and the caller masks it.
module mem_bytemask_ram
  import lsu_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = MEM_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic [NLANES-1:0]     we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [XLEN-1:0]       wdata_i,
  output logic [XLEN-1:0]       rdata_o
);

  logic [XLEN-1:0] mem_q [2**DEPTH_LOG2];
  logic [XLEN-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      for (int b = 0; b < NLANES; b++) begin
        if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory responder for the LS data port. It handles one request at a time, and the response rises LAT edges after the accept edge.
// req_ready_o is low from the accept edge until the response handshake; the response is held while resp_ready_i is low.
module lsu_mem_responder
  import lsu_mem_responder_pkg::*;
#(
  parameter int unsigned     DEPTH_LOG2 = MEM_DEPTH_LOG2,
  parameter logic [XLEN-1:0] BASE_ADDR  = MEM_BASE_ADDR,  // must be 8-byte aligned
  parameter int unsigned     LAT        = MEM_LAT         // 1..15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_wen_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [NLANES-1:0] req_wmask_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [XLEN-1:0]   resp_rdata_o,
  output logic              resp_err_o
);

  localparam int unsigned OFFW     = XLEN - 3;
  localparam bit          DIRECT   = (LAT == 1);
  localparam logic [3:0]  CNT_INIT = 4'(LAT - 1);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  req_ready_q, resp_valid_q, resp_err_q, load_ok_q;
  logic                  wen_q, err_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [XLEN-1:0]       wdata_q;
  logic [NLANES-1:0]     wmask_q;

  logic [OFFW-1:0]       word_off;
  logic                  req_err, req_fire, access_now, in_idle;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [XLEN-1:0]       ram_wdata, ram_rdata;
  logic [NLANES-1:0]     ram_we;

  // Word offset from the base. An address below the base wraps to a huge offset; the explicit compare also catches it.
  assign word_off = req_addr_i[XLEN-1:3] - BASE_ADDR[XLEN-1:3];
  assign req_err  = (req_addr_i < BASE_ADDR) || (word_off[OFFW-1:DEPTH_LOG2] != '0);
  assign req_fire = req_valid_i && req_ready_q;
  assign in_idle  = (state_q == ST_IDLE);

  // The RAM is driven in the cycle before RESP entry, so the access commits on the RESP entry edge.
  // With LAT=1 that is the accept cycle, so the live request feeds the RAM.
  assign access_now = rst_n && ((DIRECT && req_fire) || (state_q == ST_WAIT && cnt_q == '0));
  assign ram_addr   = in_idle ? word_off[DEPTH_LOG2-1:0] : idx_q;
  assign ram_wdata  = in_idle ? req_wdata_i : wdata_q;
  assign ram_we     = in_idle ? ((req_wen_i && !req_err) ? req_wmask_i : '0)
                              : ((wen_q && !err_q) ? wmask_q : '0);

  mem_bytemask_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk    (clk),
    .en_i   (access_now),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      load_ok_q    <= 1'b0;
      wen_q        <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_fire) begin
            wen_q       <= req_wen_i;
            err_q       <= req_err;
            idx_q       <= word_off[DEPTH_LOG2-1:0];
            wdata_q     <= req_wdata_i;
            wmask_q     <= req_wmask_i;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            if (DIRECT) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= req_err;
              load_ok_q    <= !req_wen_i && !req_err;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        // cnt_q holds the number of WAIT cycles still to go after this one
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            load_ok_q    <= !wen_q && !err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (resp_ready_i) begin
            state_q      <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            load_ok_q    <= 1'b0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  // The RAM read register is idle until the next access, so the masked word stays stable during RESP.
  assign resp_rdata_o = ram_rdata & {XLEN{load_ok_q}};

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Directed bench: u0 uses LAT=2 for the reset, data, mask, backpressure and range scenarios; u1 uses LAT=1 for the throughput scenario.
module tb_lsu_mem_responder;
  import lsu_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vec  = 0;
  int miss = 0;

  logic        r0_vld, r0_rdy, r0_wen, s0_vld, s0_rdy, s0_err;
  logic [63:0] r0_addr, r0_wdata, s0_rdata;
  logic [7:0]  r0_wmask;
  logic        r1_vld, r1_rdy, r1_wen, s1_vld, s1_rdy, s1_err;
  logic [63:0] r1_addr, r1_wdata, s1_rdata;
  logic [7:0]  r1_wmask;

  lsu_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(64'h8000_0000), .LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(r0_vld), .req_ready_o(r0_rdy), .req_wen_i(r0_wen), .req_addr_i(r0_addr),
    .req_wdata_i(r0_wdata), .req_wmask_i(r0_wmask),
    .resp_valid_o(s0_vld), .resp_ready_i(s0_rdy), .resp_rdata_o(s0_rdata), .resp_err_o(s0_err)
  );

  lsu_mem_responder #(.DEPTH_LOG2(12), .BASE_ADDR(64'h8000_0000), .LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(r1_vld), .req_ready_o(r1_rdy), .req_wen_i(r1_wen), .req_addr_i(r1_addr),
    .req_wdata_i(r1_wdata), .req_wmask_i(r1_wmask),
    .resp_valid_o(s1_vld), .resp_ready_i(s1_rdy), .resp_rdata_o(s1_rdata), .resp_err_o(s1_err)
  );

  function automatic logic [63:0] addr_of(input int i);
    return 64'h8000_0100 + 64'(i) * 64'd8;
  endfunction

  function automatic logic [63:0] data_of(input int i);
    return {32'hC0DE_0000 + 32'(i), 32'(i) * 32'h0101_0101 + 32'h55};
  endfunction

  // Issue one u0 request at posedge+1 with resp_ready high. Returns the edges from accept to resp_valid and the response.
  task automatic req0(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, output int lat, output logic [63:0] rdata,
                      output logic err);
    r0_wen = wen; r0_addr = addr; r0_wdata = wdata; r0_wmask = mask; r0_vld = 1'b1;
    @(posedge clk); #1;
    r0_vld = 1'b0;
    lat = 0;
    while (s0_vld !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = s0_rdata;
    err   = s0_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r0_vld = 0; r0_wen = 0; r0_addr = '0; r0_wdata = '0; r0_wmask = '0; s0_rdy = 1'b1;
    r1_vld = 0; r1_wen = 0; r1_addr = '0; r1_wdata = '0; r1_wmask = '0; s1_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (s0_vld !== 1'b0) begin miss++; $display("FAIL reset_valid: got %b expected 0", s0_vld); end
    vec++; if (s0_rdata !== 64'h0) begin miss++; $display("FAIL reset_rdata: got %h expected 0", s0_rdata); end
    vec++; if (s0_err !== 1'b0) begin miss++; $display("FAIL reset_err: got %b expected 0", s0_err); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (r0_rdy !== 1'b1) begin miss++; $display("FAIL reset_ready: got %b expected 1", r0_rdy); end
    vec++; if (s1_vld !== 1'b0) begin miss++; $display("FAIL reset_valid_u1: got %b expected 0", s1_vld); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [63:0] rd; logic er;
    req0(1'b1, 64'h8000_0010, 64'h5555_5555_5555_5555, 8'hFF, lat, rd, er);
    r0_wen = 1'b1; r0_addr = 64'h8000_0010; r0_wdata = {8{8'hAA}}; r0_wmask = 8'hFF; r0_vld = 1'b1;
    @(posedge clk); #1;
    r0_vld = 1'b0;
    vec++; if (r0_rdy !== 1'b0) begin miss++; $display("FAIL abort_wait_ready: got %b expected 0", r0_rdy); end
    #1 rst_n = 1'b0;
    #1;
    vec++; if (s0_vld !== 1'b0) begin miss++; $display("FAIL abort_valid: got %b expected 0", s0_vld); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vec++; if (r0_rdy !== 1'b1) begin miss++; $display("FAIL abort_ready: got %b expected 1", r0_rdy); end
    req0(1'b0, 64'h8000_0010, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'h5555_5555_5555_5555) begin miss++; $display("FAIL abort_dropped: got %h expected 5555555555555555", rd); end
  endtask

  task automatic test_lat2();
    int lat; logic [63:0] rd; logic er;
    req0(1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, lat, rd, er);
    vec++; if (lat !== 2) begin miss++; $display("FAIL lat2_store_lat: got %0d expected 2", lat); end
    vec++; if (rd !== 64'h0) begin miss++; $display("FAIL lat2_store_rdata: got %h expected 0", rd); end
    vec++; if (er !== 1'b0) begin miss++; $display("FAIL lat2_store_err: got %b expected 0", er); end
    req0(1'b0, 64'h8000_0008, 64'h0, 8'h00, lat, rd, er);
    vec++; if (lat !== 2) begin miss++; $display("FAIL lat2_load_lat: got %0d expected 2", lat); end
    vec++; if (rd !== 64'h1122_3344_5566_7788) begin miss++; $display("FAIL lat2_load_rdata: got %h expected 1122334455667788", rd); end
    vec++; if (er !== 1'b0) begin miss++; $display("FAIL lat2_load_err: got %b expected 0", er); end
  endtask

  task automatic test_bytemask();
    int lat; logic [63:0] rd; logic er;
    req0(1'b1, 64'h8000_0018, 64'h0, 8'hFF, lat, rd, er);
    req0(1'b1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, lat, rd, er);
    req0(1'b0, 64'h8000_0018, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'h0000_0000_FFFF_FFFF) begin miss++; $display("FAIL mask_0f: got %h expected 00000000ffffffff", rd); end
    req0(1'b1, 64'h8000_0018, 64'h1234_5678_9ABC_DEF0, 8'h00, lat, rd, er);
    vec++; if (er !== 1'b0) begin miss++; $display("FAIL mask_00_err: got %b expected 0", er); end
    req0(1'b0, 64'h8000_0018, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'h0000_0000_FFFF_FFFF) begin miss++; $display("FAIL mask_00: got %h expected 00000000ffffffff", rd); end
    req0(1'b1, 64'h8000_0018, 64'hAABB_CCDD_EEFF_0011, 8'hA0, lat, rd, er);
    req0(1'b0, 64'h8000_0018, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'hAA00_CC00_FFFF_FFFF) begin miss++; $display("FAIL mask_a0: got %h expected aa00cc00ffffffff", rd); end
  endtask

  task automatic test_backpressure();
    int lat; logic [63:0] rd; logic er;
    req0(1'b1, 64'h8000_0020, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF, lat, rd, er);
    req0(1'b1, 64'h8000_0028, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, rd, er);
    s0_rdy = 1'b0;
    r0_wen = 1'b0; r0_addr = 64'h8000_0020; r0_vld = 1'b1;
    @(posedge clk); #1;
    r0_vld = 1'b0;
    lat = 0;
    while (s0_vld !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    vec++; if (lat !== 2) begin miss++; $display("FAIL bp_lat: got %0d expected 2", lat); end
    r0_wen = 1'b1; r0_addr = 64'h8000_0028; r0_wdata = 64'hFFFF_FFFF_FFFF_FFFF; r0_wmask = 8'hFF; r0_vld = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      vec++; if (s0_vld !== 1'b1) begin miss++; $display("FAIL bp_valid[%0d]: got %b expected 1", c, s0_vld); end
      vec++; if (s0_rdata !== 64'hDEAD_BEEF_CAFE_F00D) begin miss++; $display("FAIL bp_rdata[%0d]: got %h expected deadbeefcafef00d", c, s0_rdata); end
      vec++; if (s0_err !== 1'b0) begin miss++; $display("FAIL bp_err[%0d]: got %b expected 0", c, s0_err); end
      vec++; if (r0_rdy !== 1'b0) begin miss++; $display("FAIL bp_ready[%0d]: got %b expected 0", c, r0_rdy); end
    end
    r0_vld = 1'b0;
    s0_rdy = 1'b1;
    @(posedge clk); #1;
    vec++; if (s0_vld !== 1'b0) begin miss++; $display("FAIL bp_release_valid: got %b expected 0", s0_vld); end
    vec++; if (r0_rdy !== 1'b1) begin miss++; $display("FAIL bp_release_ready: got %b expected 1", r0_rdy); end
    req0(1'b0, 64'h8000_0028, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'h0123_4567_89AB_CDEF) begin miss++; $display("FAIL bp_blocked_store: got %h expected 0123456789abcdef", rd); end
  endtask

  task automatic test_range();
    int lat; logic [63:0] rd; logic er;
    req0(1'b1, 64'h8000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 8'hFF, lat, rd, er);
    req0(1'b1, 64'h8000_7FF8, 64'hF0F0_F0F0_F0F0_F0F0, 8'hFF, lat, rd, er);
    req0(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, lat, rd, er);
    vec++; if (er !== 1'b1) begin miss++; $display("FAIL range_low_err: got %b expected 1", er); end
    vec++; if (rd !== 64'h0) begin miss++; $display("FAIL range_low_rdata: got %h expected 0", rd); end
    req0(1'b0, 64'h8000_8000, 64'h0, 8'h00, lat, rd, er);
    vec++; if (er !== 1'b1) begin miss++; $display("FAIL range_high_err: got %b expected 1", er); end
    vec++; if (rd !== 64'h0) begin miss++; $display("FAIL range_high_rdata: got %h expected 0", rd); end
    req0(1'b0, 64'h8000_7FF8, 64'h0, 8'h00, lat, rd, er);
    vec++; if (er !== 1'b0) begin miss++; $display("FAIL range_last_err: got %b expected 0", er); end
    vec++; if (rd !== 64'hF0F0_F0F0_F0F0_F0F0) begin miss++; $display("FAIL range_last_rdata: got %h expected f0f0f0f0f0f0f0f0", rd); end
    req0(1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, er);
    vec++; if (er !== 1'b1) begin miss++; $display("FAIL range_low_store_err: got %b expected 1", er); end
    req0(1'b1, 64'h8000_8000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, lat, rd, er);
    vec++; if (er !== 1'b1) begin miss++; $display("FAIL range_high_store_err: got %b expected 1", er); end
    req0(1'b0, 64'h8000_0005, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'h0F0F_0F0F_0F0F_0F0F) begin miss++; $display("FAIL range_word0: got %h expected 0f0f0f0f0f0f0f0f", rd); end
    vec++; if (er !== 1'b0) begin miss++; $display("FAIL range_word0_err: got %b expected 0", er); end
    req0(1'b0, 64'h8000_7FF8, 64'h0, 8'h00, lat, rd, er);
    vec++; if (rd !== 64'hF0F0_F0F0_F0F0_F0F0) begin miss++; $display("FAIL range_lastword: got %h expected f0f0f0f0f0f0f0f0", rd); end
  endtask

  // Sixteen u1 requests with req_valid held high. Each response must follow its accept edge, and responses must be 2 cycles apart.
  task automatic stream1(input logic wen);
    int nreq, nrsp, last;
    logic acc;
    nreq = 0; nrsp = 0; last = -1;
    r1_wen = wen; r1_wmask = 8'hFF; r1_addr = addr_of(0); r1_wdata = data_of(0); r1_vld = 1'b1;
    for (int cyc = 0; cyc < 80 && nrsp < 16; cyc++) begin
      acc = r1_vld && r1_rdy;
      @(posedge clk); #1;
      if (acc) begin
        nreq++;
        if (nreq < 16) begin r1_addr = addr_of(nreq); r1_wdata = data_of(nreq); end
        else r1_vld = 1'b0;
      end
      vec++; if (s1_vld !== acc) begin miss++; $display("FAIL tput_valid_after_accept[%0d]: got %b expected %b", cyc, s1_vld, acc); end
      if (s1_vld === 1'b1) begin
        vec++; if (s1_rdata !== (wen ? 64'h0 : data_of(nrsp))) begin miss++; $display("FAIL tput_rdata[%0d]: got %h expected %h", nrsp, s1_rdata, wen ? 64'h0 : data_of(nrsp)); end
        vec++; if (s1_err !== 1'b0) begin miss++; $display("FAIL tput_err[%0d]: got %b expected 0", nrsp, s1_err); end
        if (nrsp > 0) begin
          vec++; if (cyc - last !== 2) begin miss++; $display("FAIL tput_spacing[%0d]: got %0d expected 2", nrsp, cyc - last); end
        end
        last = cyc;
        nrsp++;
      end
    end
    r1_vld = 1'b0;
    vec++; if (nrsp !== 16) begin miss++; $display("FAIL tput_count: got %0d expected 16", nrsp); end
    @(posedge clk); #1;
  endtask

  task automatic test_throughput();
    stream1(1'b1);
    stream1(1'b0);
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_lat2();
    test_bytemask();
    test_backpressure();
    test_range();
    test_throughput();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
